// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit.
// Holds the FSM state encoding and the default datapath and register-address widths.
package fwd_hazard_unit_pkg;

  localparam int unsigned DefaultXlen = 32;
  localparam int unsigned DefaultRaW  = 5;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLuStall  = 2'd1,
    StMemWait  = 2'd2
  } state_e;

endpackage

// File: rtl/fwd_hazard_unit_src_sel.sv
// fwd_src_sel: per-operand producer match, priority select and hazard detect.
// Ports:
//   id_valid_i, rs_use_i, rs_i       - ID operand being resolved
//   ex_*, mem_*, wb_*                - pipeline producers (rd, write enable, data)
//   hold_vld_i, hold_rd_i, hold_dat_i - late-load hold buffer
//   fwd_en_o, fwd_dat_o              - operand taken from the forwarding path
//   lu_haz_o                         - youngest producer is a load still in EX
//   mw_haz_o                         - youngest producer is a load in MEM awaiting ack
module fwd_src_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned XLEN = DefaultXlen,
  parameter int unsigned RA_W = DefaultRaW
) (
  input  logic            id_valid_i,
  input  logic            rs_use_i,
  input  logic [RA_W-1:0] rs_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            ex_we_i,
  input  logic            ex_is_load_i,
  input  logic [XLEN-1:0] ex_dat_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            mem_we_i,
  input  logic            mem_is_load_i,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_dat_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            wb_we_i,
  input  logic [XLEN-1:0] wb_dat_i,
  input  logic            hold_vld_i,
  input  logic [RA_W-1:0] hold_rd_i,
  input  logic [XLEN-1:0] hold_dat_i,
  output logic            fwd_en_o,
  output logic [XLEN-1:0] fwd_dat_o,
  output logic            lu_haz_o,
  output logic            mw_haz_o
);

  logic qual;
  logic ex_match, mem_match, wb_match, hold_match;

  // x0 is hardwired to zero and never forwarded.
  assign qual       = id_valid_i & rs_use_i & (rs_i != '0);
  assign ex_match   = qual & ex_we_i  & (rs_i == ex_rd_i);
  assign mem_match  = qual & mem_we_i & (rs_i == mem_rd_i);
  assign wb_match   = qual & wb_we_i  & (rs_i == wb_rd_i);
  assign hold_match = qual & hold_vld_i & (rs_i == hold_rd_i);

  // The youngest matching producer owns the value; if its data is not ready yet,
  // older stages hold stale values and must not be used.
  always_comb begin
    fwd_en_o  = 1'b0;
    fwd_dat_o = '0;
    if (ex_match) begin
      if (!ex_is_load_i) begin
        fwd_en_o  = 1'b1;
        fwd_dat_o = ex_dat_i;
      end
    end else if (mem_match) begin
      if (!mem_is_load_i || mem_ack_i) begin
        fwd_en_o  = 1'b1;
        fwd_dat_o = mem_dat_i;
      end
    end else if (wb_match) begin
      fwd_en_o  = 1'b1;
      fwd_dat_o = wb_dat_i;
    end else if (hold_match) begin
      fwd_en_o  = 1'b1;
      fwd_dat_o = hold_dat_i;
    end
  end

  assign lu_haz_o = ex_match & ex_is_load_i;
  assign mw_haz_o = mem_match & mem_is_load_i & ~mem_ack_i & ~ex_match;

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and pipeline hazard control between ID and EX.
// Ports:
//   clk_i, rst_i               - clock, synchronous active-high reset
//   id_valid_i, id_rs_i,
//   id_rs_use_i                - ID operands (operand k at id_rs_i[k*RA_W +: RA_W])
//   ex_*, mem_*, wb_*          - producer stages; mem_ack_i qualifies load data
//   fwd_en_o, fwd_dat_o        - per-operand forwarding select and data
//   stall_o, bubble_o          - freeze front end / inject NOP into EX
//   mem_timeout_o              - sticky: MEM_WAIT lasted TIMEOUT cycles without ack
//   stall_cnt_o                - saturating count of stalled cycles
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned XLEN    = DefaultXlen,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned RA_W    = DefaultRaW,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    id_valid_i,
  input  logic [NUM_SRC*RA_W-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]      id_rs_use_i,
  input  logic [RA_W-1:0]         ex_rd_i,
  input  logic                    ex_we_i,
  input  logic                    ex_is_load_i,
  input  logic [XLEN-1:0]         ex_dat_i,
  input  logic [RA_W-1:0]         mem_rd_i,
  input  logic                    mem_we_i,
  input  logic                    mem_is_load_i,
  input  logic                    mem_ack_i,
  input  logic [XLEN-1:0]         mem_dat_i,
  input  logic [RA_W-1:0]         wb_rd_i,
  input  logic                    wb_we_i,
  input  logic [XLEN-1:0]         wb_dat_i,
  output logic [NUM_SRC-1:0]      fwd_en_o,
  output logic [NUM_SRC*XLEN-1:0] fwd_dat_o,
  output logic                    stall_o,
  output logic                    bubble_o,
  output logic                    mem_timeout_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [NUM_SRC-1:0]      sel_en, lu_vec, mw_vec;
  logic [NUM_SRC*XLEN-1:0] sel_dat;
  logic                    lu_haz, mw_haz, stall;

  state_e          state_q;
  logic            hold_vld_q;
  logic [RA_W-1:0] hold_rd_q;
  logic [XLEN-1:0] hold_dat_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic            timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_sel #(
      .XLEN (XLEN),
      .RA_W (RA_W)
    ) u_sel (
      .id_valid_i    (id_valid_i),
      .rs_use_i      (id_rs_use_i[k]),
      .rs_i          (id_rs_i[k*RA_W +: RA_W]),
      .ex_rd_i       (ex_rd_i),
      .ex_we_i       (ex_we_i),
      .ex_is_load_i  (ex_is_load_i),
      .ex_dat_i      (ex_dat_i),
      .mem_rd_i      (mem_rd_i),
      .mem_we_i      (mem_we_i),
      .mem_is_load_i (mem_is_load_i),
      .mem_ack_i     (mem_ack_i),
      .mem_dat_i     (mem_dat_i),
      .wb_rd_i       (wb_rd_i),
      .wb_we_i       (wb_we_i),
      .wb_dat_i      (wb_dat_i),
      .hold_vld_i    (hold_vld_q),
      .hold_rd_i     (hold_rd_q),
      .hold_dat_i    (hold_dat_q),
      .fwd_en_o      (sel_en[k]),
      .fwd_dat_o     (sel_dat[k*XLEN +: XLEN]),
      .lu_haz_o      (lu_vec[k]),
      .mw_haz_o      (mw_vec[k])
    );
  end

  assign lu_haz = |lu_vec;
  assign mw_haz = |mw_vec;
  assign stall  = ~rst_i & (lu_haz | mw_haz);

  assign stall_o       = stall;
  assign bubble_o      = stall;
  assign fwd_en_o      = rst_i ? '0 : sel_en;
  assign fwd_dat_o     = rst_i ? '0 : sel_dat;
  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      hold_vld_q  <= 1'b0;
      hold_rd_q   <= '0;
      hold_dat_q  <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end

      // Consumer saw the held data on a non-stalled RUN cycle; it is no longer needed.
      if ((state_q == StRun) && !stall) begin
        hold_vld_q <= 1'b0;
      end
      // Register file now holds the value, so the buffered copy would only go stale.
      if (wb_we_i && (wb_rd_i == hold_rd_q)) begin
        hold_vld_q <= 1'b0;
      end

      unique case (state_q)
        StRun: begin
          if (lu_haz) begin
            state_q <= StLuStall;
          end else if (mw_haz) begin
            state_q    <= StMemWait;
            wait_cnt_q <= '0;
          end
        end
        StLuStall: begin
          if (mw_haz) begin
            state_q    <= StMemWait;
            wait_cnt_q <= '0;
          end else begin
            state_q <= StRun;
          end
        end
        StMemWait: begin
          if (mem_ack_i) begin
            state_q    <= StRun;
            hold_vld_q <= 1'b1;
            hold_rd_q  <= mem_rd_i;
            hold_dat_q <= mem_dat_i;
          end else begin
            // Counter parks at TIMEOUT; the flag stays sticky until reset.
            if (wait_cnt_q != WaitW'(TIMEOUT)) begin
              wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end
            if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned TIMEOUT = 3;
  localparam int unsigned CNT_W   = 8;

  typedef struct packed {
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_use;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_is_load;
    logic [31:0] ex_dat;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic        mem_is_load;
    logic        mem_ack;
    logic [31:0] mem_dat;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_dat;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic [1:0]  en;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        stall;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stim_t cur = '0;

  logic [1:0]       fwd_en_o;
  logic [63:0]      fwd_dat_o;
  logic             stall_o, bubble_o, mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_wait, m_after_lu, m_timeout, m_hvld;
  int          m_waited, m_cnt;
  logic [4:0]  m_hrd;
  logic [31:0] m_hdat;
  // Reference model combinational results
  bit          e_lu, e_mw;
  logic [1:0]  e_en;
  logic [31:0] e_dat [2];

  vec_t vecs[$];

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC),
    .RA_W    (RA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (cur.id_valid),
    .id_rs_i       (cur.id_rs),
    .id_rs_use_i   (cur.id_rs_use),
    .ex_rd_i       (cur.ex_rd),
    .ex_we_i       (cur.ex_we),
    .ex_is_load_i  (cur.ex_is_load),
    .ex_dat_i      (cur.ex_dat),
    .mem_rd_i      (cur.mem_rd),
    .mem_we_i      (cur.mem_we),
    .mem_is_load_i (cur.mem_is_load),
    .mem_ack_i     (cur.mem_ack),
    .mem_dat_i     (cur.mem_dat),
    .wb_rd_i       (cur.wb_rd),
    .wb_we_i       (cur.wb_we),
    .wb_dat_i      (cur.wb_dat),
    .fwd_en_o      (fwd_en_o),
    .fwd_dat_o     (fwd_dat_o),
    .stall_o       (stall_o),
    .bubble_o      (bubble_o),
    .mem_timeout_o (mem_timeout_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest producer writing the register decides: forward if its data is ready,
  // otherwise the operand must wait (load in EX, or load in MEM without ack).
  task automatic model_comb();
    logic [4:0]  rd  [4];
    logic        we  [4];
    logic        rdy [4];
    logic [31:0] dat [4];
    logic [4:0]  rs;
    bit          found;
    rd[0] = cur.ex_rd;  we[0] = cur.ex_we;  rdy[0] = !cur.ex_is_load; dat[0] = cur.ex_dat;
    rd[1] = cur.mem_rd; we[1] = cur.mem_we; dat[1] = cur.mem_dat;
    rdy[1] = !cur.mem_is_load || cur.mem_ack;
    rd[2] = cur.wb_rd;  we[2] = cur.wb_we;  rdy[2] = 1'b1; dat[2] = cur.wb_dat;
    rd[3] = m_hrd;      we[3] = m_hvld;     rdy[3] = 1'b1; dat[3] = m_hdat;
    e_lu = 0;
    e_mw = 0;
    for (int k = 0; k < 2; k++) begin
      e_en[k]  = 1'b0;
      e_dat[k] = '0;
      rs = cur.id_rs[k*5 +: 5];
      found = 0;
      if (!rst && cur.id_valid && cur.id_rs_use[k] && rs != 0) begin
        for (int s = 0; s < 4; s++) begin
          if (!found && we[s] && rd[s] == rs) begin
            found = 1;
            if (rdy[s]) begin
              e_en[k]  = 1'b1;
              e_dat[k] = dat[s];
            end else if (s == 0) begin
              e_lu = 1;
            end else begin
              e_mw = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic model_seq();
    bit stall, in_run, capture;
    model_comb();
    if (rst) begin
      m_wait = 0; m_after_lu = 0; m_waited = 0; m_timeout = 0; m_cnt = 0; m_hvld = 0;
    end else begin
      stall   = e_lu || e_mw;
      in_run  = !m_wait && !m_after_lu;
      capture = m_wait && cur.mem_ack;
      if (stall && m_cnt < 255) m_cnt++;
      if (capture) begin
        m_hvld = 1; m_hrd = cur.mem_rd; m_hdat = cur.mem_dat;
      end else if ((in_run && !stall) || (cur.wb_we && cur.wb_rd == m_hrd)) begin
        m_hvld = 0;
      end
      if (m_wait) begin
        if (cur.mem_ack) m_wait = 0;
        else begin
          m_waited++;
          if (m_waited >= TIMEOUT) m_timeout = 1;
        end
      end else if (m_after_lu) begin
        m_after_lu = 0;
        if (e_mw) begin m_wait = 1; m_waited = 0; end
      end else if (e_lu) begin
        m_after_lu = 1;
      end else if (e_mw) begin
        m_wait = 1; m_waited = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    model_comb();
    chk({tag, "/stall"},   64'(stall_o),       64'(e_lu || e_mw));
    chk({tag, "/bubble"},  64'(bubble_o),      64'(e_lu || e_mw));
    chk({tag, "/fwd_en"},  64'(fwd_en_o),      64'(e_en));
    chk({tag, "/fwd_dat"}, fwd_dat_o,          {e_dat[1], e_dat[0]});
    chk({tag, "/timeout"}, 64'(mem_timeout_o), 64'(m_timeout));
    chk({tag, "/cnt"},     64'(stall_cnt_o),   64'(m_cnt));
  endtask

  // Inputs are already driven (1 time unit after a rising edge).
  task automatic step(input string tag);
    #2;
    check_model(tag);
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cur = '0;
    step("reset");
    rst = 1'b0;
  endtask

  task automatic add(input stim_t s, input logic [1:0] en, input logic [31:0] d0,
                     input logic [31:0] d1, input logic st, input string name);
    vec_t v;
    v.in = s; v.en = en; v.d0 = d0; v.d1 = d1; v.stall = st; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.id_valid    = ($urandom_range(9) != 0);
    s.id_rs       = {5'($urandom_range(3)), 5'($urandom_range(3))};
    s.id_rs_use   = 2'($urandom_range(3));
    s.ex_rd       = 5'($urandom_range(3));
    s.ex_we       = 1'($urandom_range(1));
    s.ex_is_load  = ($urandom_range(2) == 0);
    s.ex_dat      = $urandom;
    s.mem_rd      = 5'($urandom_range(3));
    s.mem_we      = 1'($urandom_range(1));
    s.mem_is_load = ($urandom_range(2) == 0);
    s.mem_ack     = 1'($urandom_range(1));
    s.mem_dat     = $urandom;
    s.wb_rd       = 5'($urandom_range(3));
    s.wb_we       = 1'($urandom_range(1));
    s.wb_dat      = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s, ml;
    @(posedge clk);
    model_seq();
    #1;
    do_reset();

    // ---- Table-driven combinational vectors (run in order from reset) ----
    s = '0; s.id_valid = 1; s.id_rs[4:0] = 5; s.id_rs_use = 2'b01;
    s.ex_rd = 5; s.ex_we = 1; s.ex_dat = 32'h11;
    add(s, 2'b01, 32'h11, 0, 0, "alu_chain");
    s = '0; s.id_valid = 1; s.id_rs = {5'd9, 5'd9}; s.id_rs_use = 2'b11;
    s.ex_rd = 9; s.ex_we = 1; s.ex_dat = 1; s.mem_rd = 9; s.mem_we = 1; s.mem_dat = 2;
    s.wb_rd = 9; s.wb_we = 1; s.wb_dat = 3;
    add(s, 2'b11, 1, 1, 0, "priority");
    s.id_rs = '0; s.id_rs_use = 2'b01; s.ex_rd = 0; s.mem_rd = 0; s.wb_rd = 0;
    add(s, 2'b00, 0, 0, 0, "x0");
    s = '0; s.id_valid = 1; s.id_rs[9:5] = 4; s.id_rs_use = 2'b10;
    s.mem_rd = 4; s.mem_we = 1; s.mem_dat = 32'h22;
    add(s, 2'b10, 0, 32'h22, 0, "mem_fwd");
    s = '0; s.id_valid = 1; s.id_rs[4:0] = 6; s.id_rs_use = 2'b01;
    s.wb_rd = 6; s.wb_we = 1; s.wb_dat = 32'h33;
    add(s, 2'b01, 32'h33, 0, 0, "wb_fwd");
    s = '0; s.id_valid = 1; s.id_rs[9:5] = 7; s.id_rs_use = 2'b10;
    s.ex_rd = 7; s.ex_we = 1; s.ex_is_load = 1;
    add(s, 2'b00, 0, 0, 1, "load_use");
    s = '0; s.id_valid = 1; s.id_rs[4:0] = 3; s.id_rs_use = 2'b01;
    s.mem_rd = 3; s.mem_we = 1; s.mem_is_load = 1;
    add(s, 2'b00, 0, 0, 1, "mem_wait");
    s.mem_ack = 1; s.mem_dat = 32'h55;
    add(s, 2'b01, 32'h55, 0, 0, "mem_ack");
    s = '0; s.id_rs[4:0] = 7; s.id_rs_use = 2'b01; s.ex_rd = 7; s.ex_we = 1; s.ex_is_load = 1;
    add(s, 2'b00, 0, 0, 0, "id_invalid");
    s.id_valid = 1; s.id_rs_use = 2'b00;
    add(s, 2'b00, 0, 0, 0, "use_off");
    s = '0; s.id_valid = 1; s.id_rs[4:0] = 3; s.id_rs_use = 2'b01;
    s.ex_rd = 3; s.ex_we = 1; s.ex_dat = 32'h77; s.mem_rd = 3; s.mem_we = 1; s.mem_is_load = 1;
    add(s, 2'b01, 32'h77, 0, 0, "ex_masks_mem");

    foreach (vecs[i]) begin
      cur = vecs[i].in;
      #2;
      chk({vecs[i].name, "/stall"},  64'(stall_o),  64'(vecs[i].stall));
      chk({vecs[i].name, "/bubble"}, 64'(bubble_o), 64'(vecs[i].stall));
      chk({vecs[i].name, "/fwd_en"}, 64'(fwd_en_o), 64'(vecs[i].en));
      chk({vecs[i].name, "/fwd_dat"}, fwd_dat_o, {vecs[i].d1, vecs[i].d0});
      chk({vecs[i].name, "/cnt"}, 64'(stall_cnt_o), 64'(m_cnt));
      @(posedge clk);
      model_seq();
      #1;
    end

    // ---- Load-use followed by ack the next cycle ----
    do_reset();
    cur = '0; cur.id_valid = 1; cur.id_rs[9:5] = 7; cur.id_rs_use = 2'b10;
    cur.ex_rd = 7; cur.ex_we = 1; cur.ex_is_load = 1;
    #2; chk("lu/stall", 64'(stall_o), 1); chk("lu/bubble", 64'(bubble_o), 1);
    step("lu1");
    cur.ex_we = 0; cur.ex_is_load = 0;
    cur.mem_rd = 7; cur.mem_we = 1; cur.mem_is_load = 1; cur.mem_ack = 1; cur.mem_dat = 32'hCAFE;
    #2;
    chk("lu_ack/fwd_en", 64'(fwd_en_o), 64'(2'b10));
    chk("lu_ack/dat", 64'(fwd_dat_o[63:32]), 64'h0000_CAFE);
    chk("lu_ack/stall", 64'(stall_o), 0);
    chk("lu_ack/cnt", 64'(stall_cnt_o), 1);
    step("lu2");

    // ---- Slow memory: 4 stalled cycles then ack; hold buffer used next cycle ----
    do_reset();
    ml = '0; ml.id_valid = 1; ml.id_rs[4:0] = 3; ml.id_rs_use = 2'b01;
    ml.mem_rd = 3; ml.mem_we = 1; ml.mem_is_load = 1;
    cur = ml;
    for (int i = 0; i < 4; i++) begin
      #2; chk("slow/stall", 64'(stall_o), 1);
      step("slow_wait");
    end
    cur.mem_ack = 1; cur.mem_dat = 32'h55;
    #2;
    chk("slow_ack/stall", 64'(stall_o), 0);
    chk("slow_ack/dat", 64'(fwd_dat_o[31:0]), 64'h55);
    chk("slow_ack/cnt", 64'(stall_cnt_o), 4);
    step("slow_ack");
    cur = '0; cur.id_valid = 1; cur.id_rs[4:0] = 3; cur.id_rs_use = 2'b01;
    #2;
    chk("hold/fwd_en", 64'(fwd_en_o), 64'(2'b01));
    chk("hold/dat", 64'(fwd_dat_o[31:0]), 64'h55);
    step("hold_use");
    #2; chk("hold_clear/fwd_en", 64'(fwd_en_o), 0);
    step("hold_clear");

    // ---- Timeout: sticky until reset ----
    do_reset();
    cur = ml;
    for (int i = 1; i <= 5; i++) begin
      #2; chk("timeout/rise", 64'(mem_timeout_o), 64'(i >= 5));
      step("timeout_wait");
    end
    cur = '0;
    step("timeout_idle");
    #2; chk("timeout/sticky", 64'(mem_timeout_o), 1);
    cur.id_valid = 1; cur.id_rs[4:0] = 5; cur.id_rs_use = 2'b01;
    cur.ex_rd = 5; cur.ex_we = 1; cur.ex_dat = 32'h99;
    rst = 1;
    #2;
    chk("rst/fwd_en", 64'(fwd_en_o), 0);
    chk("rst/fwd_dat", fwd_dat_o, 0);
    step("rst");
    rst = 0;
    cur = '0;
    #2;
    chk("rst/timeout", 64'(mem_timeout_o), 0);
    chk("rst/cnt", 64'(stall_cnt_o), 0);
    step("post_rst");

    // ---- Reset in the middle of MEM_WAIT ----
    do_reset();
    cur = ml;
    step("mw1");
    step("mw2");
    rst = 1;
    #2; chk("mw_rst/stall", 64'(stall_o), 0);
    step("mw_rst");
    rst = 0;
    cur = ml; cur.mem_ack = 1; cur.mem_dat = 32'hABCD;
    step("mw_after_ack");
    cur = '0; cur.id_valid = 1; cur.id_rs[4:0] = 3; cur.id_rs_use = 2'b01;
    #2; chk("mw_rst/no_hold", 64'(fwd_en_o), 0);
    step("mw_after");

    // ---- Stall counter saturation ----
    do_reset();
    cur = ml;
    for (int i = 0; i < 300; i++) step("sat");
    #2; chk("sat/cnt", 64'(stall_cnt_o), 255);

    // ---- Randomized run against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cur = rnd_stim();
      rst = ($urandom_range(99) == 0);
      step("rnd");
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
